// File: rtl/d_branch_predict_ctrl.sv
// Decode-stage branch resolve with an F-stage direct-mapped BTB and 2-bit direction counters.
// Optional BRANCH_STATS_EN builds resolved-branch / mispredict counters.
module d_branch_predict_ctrl #(
  parameter int PC_W      = 32,
  parameter int BTB_DEPTH = 16,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PC_W-1:0]   pc_F,
  output logic              pred_taken_F,
  output logic [PC_W-1:0]   pred_target_F,
  input  logic              valid_D,
  input  logic              stall_D,
  input  logic [31:0]       ins_D,
  input  logic [PC_W-1:0]   pc_D,
  input  logic              pred_taken_D,
  input  logic [PC_W-1:0]   pred_target_D,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  output logic              j,
  output logic              jal,
  output logic              jr,
  output logic              link,
  output logic              branch,
  output logic              ext_op,
  output logic [2:0]        cmp_op,
  output logic              taken_D,
  output logic [PC_W-1:0]   link_addr,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [STAT_W-1:0] stat_br,
  output logic [STAT_W-1:0] stat_mis
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int TGT_W = PC_W - 2;

  logic [BTB_DEPTH-1:0]            btb_vld, btb_unc;
  logic [BTB_DEPTH-1:0][TAG_W-1:0] btb_tag;
  logic [BTB_DEPTH-1:0][TGT_W-1:0] btb_tgt;
  logic [BTB_DEPTH-1:0][1:0]       btb_ctr;

  logic [IDX_W-1:0] idx_F, idx_D;
  logic [TAG_W-1:0] tag_F, tag_D;
  logic             hit_F, hit_D;
  logic             is_cond, cond_ok, mis, upd;
  logic [PC_W-1:0]  pc4, br_tgt, jimm_tgt, act_tgt;
  logic [5:0]       op, funct;
  logic [4:0]       rt_f;
  logic [1:0]       unused_pc_lo;

  assign unused_pc_lo = pc_F[1:0];
  assign op    = ins_D[31:26];
  assign rt_f  = ins_D[20:16];
  assign funct = ins_D[5:0];

  always_comb begin
    j = 1'b0; jal = 1'b0; jr = 1'b0; link = 1'b0;
    branch = 1'b0; ext_op = 1'b0; cmp_op = 3'd0; is_cond = 1'b0;
    case (op)
      6'b000100: begin branch = 1'b1; is_cond = 1'b1; cmp_op = 3'd0; end
      6'b000101: begin branch = 1'b1; is_cond = 1'b1; cmp_op = 3'd1; end
      6'b000110: begin branch = 1'b1; is_cond = 1'b1; cmp_op = 3'd3; end
      6'b000111: begin branch = 1'b1; is_cond = 1'b1; cmp_op = 3'd4; end
      6'b000001: begin
        // REGIMM: rt[4] selects the linking form, rt[0] ltz vs gez
        case (rt_f)
          5'b00000: begin branch = 1'b1; is_cond = 1'b1; cmp_op = 3'd2; end
          5'b00001: begin branch = 1'b1; is_cond = 1'b1; cmp_op = 3'd5; end
          5'b10000: begin branch = 1'b1; is_cond = 1'b1; cmp_op = 3'd2; link = 1'b1; end
          5'b10001: begin branch = 1'b1; is_cond = 1'b1; cmp_op = 3'd5; link = 1'b1; end
          default: ;
        endcase
      end
      6'b000010: begin j = 1'b1; branch = 1'b1; cmp_op = 3'd6; end
      6'b000011: begin jal = 1'b1; link = 1'b1; branch = 1'b1; cmp_op = 3'd6; end
      6'b000000: begin
        if (funct == 6'b001000) begin
          jr = 1'b1; branch = 1'b1; cmp_op = 3'd6;
        end else if (funct == 6'b001001) begin
          jr = 1'b1; link = 1'b1; branch = 1'b1; cmp_op = 3'd6;
        end
      end
      6'b001100, 6'b001101, 6'b001110: ext_op = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (cmp_op)
      3'd0:    cond_ok = (rs_val == rt_val);
      3'd1:    cond_ok = (rs_val != rt_val);
      3'd2:    cond_ok = rs_val[31];
      3'd3:    cond_ok = rs_val[31] | (rs_val == 32'd0);
      3'd4:    cond_ok = ~rs_val[31] & (rs_val != 32'd0);
      3'd5:    cond_ok = ~rs_val[31];
      3'd6:    cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign taken_D   = branch & cond_ok;
  assign pc4       = pc_D + PC_W'(4);
  assign link_addr = pc4;
  assign br_tgt    = pc4 + {{(PC_W-18){ins_D[15]}}, ins_D[15:0], 2'b00};
  assign jimm_tgt  = {pc4[PC_W-1:28], ins_D[25:0], 2'b00};
  assign act_tgt   = is_cond ? br_tgt : (j | jal) ? jimm_tgt : rs_val[PC_W-1:0];

  assign mis         = (taken_D != pred_taken_D) | (taken_D & (act_tgt != pred_target_D));
  assign upd         = valid_D & ~stall_D;
  assign redirect    = upd & reset_n & mis;
  assign redirect_pc = taken_D ? act_tgt : pc4;

  // F lookup reads registered state, so a same-cycle D write is seen only next cycle
  assign idx_F         = pc_F[IDX_W+1:2];
  assign tag_F         = pc_F[PC_W-1:IDX_W+2];
  assign hit_F         = btb_vld[idx_F] & (btb_tag[idx_F] == tag_F);
  assign pred_taken_F  = reset_n & hit_F & (btb_unc[idx_F] | btb_ctr[idx_F][1]);
  assign pred_target_F = pred_taken_F ? {btb_tgt[idx_F], 2'b00} : '0;

  assign idx_D = pc_D[IDX_W+1:2];
  assign tag_D = pc_D[PC_W-1:IDX_W+2];
  assign hit_D = btb_vld[idx_D] & (btb_tag[idx_D] == tag_D);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btb_vld <= '0;
      btb_unc <= '0;
      btb_ctr <= '0;
      btb_tag <= '0;
      btb_tgt <= '0;
    end else if (upd) begin
      if (is_cond) begin
        if (hit_D) begin
          if (taken_D) begin
            if (btb_ctr[idx_D] != 2'b11) btb_ctr[idx_D] <= btb_ctr[idx_D] + 2'd1;
            btb_tgt[idx_D] <= act_tgt[PC_W-1:2];
          end else if (btb_ctr[idx_D] != 2'b00) begin
            btb_ctr[idx_D] <= btb_ctr[idx_D] - 2'd1;
          end
        end else if (taken_D) begin
          btb_vld[idx_D] <= 1'b1;
          btb_unc[idx_D] <= 1'b0;
          btb_ctr[idx_D] <= 2'b10;
          btb_tag[idx_D] <= tag_D;
          btb_tgt[idx_D] <= act_tgt[PC_W-1:2];
        end
      end else if (j | jal) begin
        btb_vld[idx_D] <= 1'b1;
        btb_unc[idx_D] <= 1'b1;
        btb_ctr[idx_D] <= 2'b11;
        btb_tag[idx_D] <= tag_D;
        btb_tgt[idx_D] <= act_tgt[PC_W-1:2];
      end else if (hit_D) begin
        // register jumps and non-branches must never be predicted from a stale entry
        btb_vld[idx_D] <= 1'b0;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_br  <= '0;
      stat_mis <= '0;
    end else begin
      if (upd & branch) stat_br  <= stat_br + STAT_W'(1);
      if (redirect)     stat_mis <= stat_mis + STAT_W'(1);
    end
  end
`else
  assign stat_br  = '0;
  assign stat_mis = '0;
`endif

endmodule
